multififo_enq_arbiter: RTL and testbench

- Shares the multi-element enqueue port of one MultiFifo instance among R requesters.
- Each requester offers 1..N elements as an all-or-nothing burst. One burst is granted per cycle, in round-robin order, only if it fits the FIFO's free space.
- A starvation lock keeps large bursts from being skipped forever by small ones.
- The enqueue port is driven from registers; in-flight elements are counted against free space.

---
 rtl/multififo_enq_arbiter.sv | 127 ++++++++++++
 tb/tb_multififo_enq_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multififo_enq_arbiter.sv
// Round-robin arbiter sharing one MultiFifo multi-element enqueue port among R requesters.
// Bursts are all-or-nothing, granted only when they fit; a starvation lock protects large bursts.
module multififo_enq_arbiter #(
    parameter type T              = logic [7:0],
    parameter int  N              = 4,
    parameter int  MAX_CAPACITY   = 16,
    parameter int  R              = 4,
    parameter int  STARVE_LIMIT   = 4,
    parameter int  INTERFACE_BITS = $clog2(N + 1),
    parameter int  CAPACITYBITS   = $clog2(MAX_CAPACITY + 1),
    parameter int  RBITS          = $clog2(R)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [R-1:0][INTERFACE_BITS-1:0]    req_count,
    input  T     [R-1:0][N-1:0]                 req_data,
    output logic [R-1:0]                        req_ack,
    input  logic [CAPACITYBITS-1:0]             fifo_fill_level,
    output logic [INTERFACE_BITS-1:0]           fifo_valid_in,
    output T     [N-1:0]                        fifo_data_in,
    output logic [RBITS-1:0]                    grant_id,
    output logic                                starve_lock
);
    localparam int FW    = CAPACITYBITS + 1;
    localparam int SBITS = $clog2(STARVE_LIMIT + 1);

    logic [INTERFACE_BITS-1:0] r_valid_in;
    T     [N-1:0]              r_data_in;
    logic [RBITS-1:0]          r_grant_id;
    logic [RBITS-1:0]          r_ptr;
    logic                      r_lock;
    logic [SBITS-1:0]          r_skip_cnt;

    logic [FW-1:0]             w_free;
    logic [R-1:0]              w_eligible;
    logic                      w_grant_vld;
    logic [RBITS-1:0]          w_grant_idx;
    int                        w_idx;

    function automatic logic [RBITS-1:0] f_next(input logic [RBITS-1:0] i);
        return (i == RBITS'(R - 1)) ? '0 : i + 1'b1;
    endfunction

    // In-flight elements on the enqueue port are not yet in fill_level, so they are subtracted too.
    assign w_free = FW'(MAX_CAPACITY) - FW'(fifo_fill_level) - FW'(r_valid_in);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_eligible = '0;
        for (int j = 0; j < R; j++) begin
            w_eligible[j] = (req_count[j] != '0) && !w_free[FW-1] && (FW'(req_count[j]) <= w_free);
        end
    end

    // Search runs from the farthest candidate back to ptr so the last hit is the first in rotation.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_ptr;
        w_idx       = 0;
        if (r_lock) begin
            w_grant_vld = w_eligible[r_ptr];
        end else begin
            for (int k = R - 1; k >= 0; k--) begin
                w_idx = (int'(r_ptr) + k) % R;
                if (w_eligible[w_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = RBITS'(w_idx);
                end
            end
        end
    end

    always_comb begin
        req_ack = '0;
        if (rstn && w_grant_vld) req_ack[w_grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid_in <= '0;
            // NOTE: the payload register is cleared on reset because the FIFO port exposes it directly.
            r_data_in  <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_skip_cnt <= '0;
        end else begin
            if (w_grant_vld) begin
                r_valid_in <= req_count[w_grant_idx];
                r_data_in  <= req_data[w_grant_idx];
                r_grant_id <= w_grant_idx;
            end else begin
                r_valid_in <= '0;
            end

            if (req_count[r_ptr] == '0) begin
                if (w_grant_vld) r_ptr <= f_next(w_grant_idx);
                r_skip_cnt <= '0;
                r_lock     <= 1'b0;
            end else if (w_grant_vld && (w_grant_idx == r_ptr)) begin
                r_ptr      <= f_next(r_ptr);
                r_skip_cnt <= '0;
                r_lock     <= 1'b0;
            end else begin
                // Priority requester is waiting: count the skip and lock once the limit is reached.
                if (r_skip_cnt < SBITS'(STARVE_LIMIT)) r_skip_cnt <= r_skip_cnt + 1'b1;
                if (int'(r_skip_cnt) + 1 >= STARVE_LIMIT) r_lock <= 1'b1;
            end
        end
    end

    assign fifo_valid_in = r_valid_in;
    assign fifo_data_in  = r_data_in;
    assign grant_id      = r_grant_id;
    assign starve_lock   = r_lock;

    generate
        for (genvar j = 0; j < R; j++) begin : g_count_chk
            a_count_legal: assert property (@(posedge clk) disable iff (!rstn)
                req_count[j] <= INTERFACE_BITS'(N));
        end
    endgenerate

    a_free_nonneg: assert property (@(posedge clk) disable iff (!rstn) !w_free[FW-1]);

endmodule

// File: tb/tb_multififo_enq_arbiter.sv
// Self-checking bench for multififo_enq_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_multififo_enq_arbiter;
    localparam int R    = 4;
    localparam int N    = 4;
    localparam int MAXC = 16;
    localparam int SL   = 2;
    localparam int IB   = 3;
    localparam int CB   = 5;
    localparam int RB   = 2;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic [R-1:0][IB-1:0]       req_count = '0;
    logic [R-1:0][N-1:0][7:0]   req_data = '0;
    logic [R-1:0]               req_ack;
    logic [CB-1:0]              fill = '0;
    logic [IB-1:0]              fifo_valid_in;
    logic [N-1:0][7:0]          fifo_data_in;
    logic [RB-1:0]              grant_id;
    logic                       starve_lock;

    int total = 0;
    int bad   = 0;

    multififo_enq_arbiter #(
        .T(logic [7:0]), .N(N), .MAX_CAPACITY(MAXC), .R(R), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rstn(rstn), .req_count(req_count), .req_data(req_data),
        .req_ack(req_ack), .fifo_fill_level(fill), .fifo_valid_in(fifo_valid_in),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .starve_lock(starve_lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state, kept as plain integers.
    int                 m_ptr, m_skip, m_gid, m_valid, m_g;
    logic               m_lock;
    logic [N-1:0][7:0]  m_data;
    logic [R-1:0]       m_ack;
    int                 prev_valid, prev_g;
    logic [R-1:0]       last_ack;

    function automatic void model_reset();
        m_ptr = 0; m_skip = 0; m_gid = 0; m_valid = 0; m_g = -1;
        m_lock = 1'b0; m_data = '0; m_ack = '0;
    endfunction

    // Walk the rotation from ptr; take the first requester whose burst fits the free space.
    function automatic void model_comb();
        int free;
        int j;
        free = MAXC - int'(fill) - m_valid;
        m_g = -1;
        for (int k = 0; k < R; k++) begin
            j = (m_ptr + k) % R;
            if (m_g < 0 && (!m_lock || j == m_ptr) &&
                int'(req_count[j]) != 0 && int'(req_count[j]) <= free)
                m_g = j;
        end
        m_ack = '0;
        if (m_g >= 0) m_ack[m_g] = 1'b1;
    endfunction

    function automatic void model_seq();
        int pc;
        pc = int'(req_count[m_ptr]);
        if (m_g >= 0) begin
            m_valid = int'(req_count[m_g]);
            m_data  = req_data[m_g];
            m_gid   = m_g;
        end else begin
            m_valid = 0;
        end
        if (pc == 0) begin
            if (m_g >= 0) m_ptr = (m_g + 1) % R;
            m_skip = 0; m_lock = 1'b0;
        end else if (m_g == m_ptr) begin
            m_ptr = (m_ptr + 1) % R;
            m_skip = 0; m_lock = 1'b0;
        end else begin
            if (m_skip + 1 >= SL) m_lock = 1'b1;
            m_skip = (m_skip + 1 > SL) ? SL : m_skip + 1;
        end
    endfunction

    task automatic reset_dut();
        rstn = 1'b0;
        req_count = '0;
        fill = '0;
        #3;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: compare DUT against model at the negedge, then advance the model at the edge.
    task automatic cycle_check(input string tag);
        @(negedge clk);
        model_comb();
        last_ack = req_ack;
        check({tag, ".ack"},   64'(req_ack),       64'(m_ack));
        check({tag, ".valid"}, 64'(fifo_valid_in), 64'(m_valid));
        check({tag, ".gid"},   64'(grant_id),      64'(m_gid));
        check({tag, ".lock"},  64'(starve_lock),   64'(m_lock));
        check({tag, ".data"},  64'(fifo_data_in),  64'(m_data));
        @(posedge clk);
        prev_valid = m_valid;
        prev_g     = m_g;
        model_seq();
        #1;
    endtask

    typedef struct {
        logic [CB-1:0]        fill;
        logic [R-1:0][IB-1:0] cnt;
        logic [R-1:0]         ack;
        logic [IB-1:0]        valid;
        logic [RB-1:0]        gid;
    } vec_t;

    vec_t              vt [8];
    logic [N-1:0][7:0] exp_d;
    int                fill_i, deq;

    initial begin
        // Each vector starts from reset (ptr=0); counts listed R3..R0.
        vt[0] = '{5'd0,  {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, 3'd3, 2'd0};
        vt[1] = '{5'd0,  {3'd1, 3'd2, 3'd0, 3'd0}, 4'b0100, 3'd2, 2'd2};
        vt[2] = '{5'd14, {3'd0, 3'd0, 3'd2, 3'd3}, 4'b0010, 3'd2, 2'd1};
        vt[3] = '{5'd16, {3'd1, 3'd1, 3'd1, 3'd1}, 4'b0000, 3'd0, 2'd0};
        vt[4] = '{5'd12, {3'd0, 3'd0, 3'd0, 3'd4}, 4'b0001, 3'd4, 2'd0};
        vt[5] = '{5'd13, {3'd3, 3'd0, 3'd0, 3'd4}, 4'b1000, 3'd3, 2'd3};
        vt[6] = '{5'd15, {3'd2, 3'd2, 3'd1, 3'd2}, 4'b0010, 3'd1, 2'd1};
        vt[7] = '{5'd0,  {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 3'd0, 2'd0};

        for (int j = 0; j < R; j++)
            for (int e = 0; e < N; e++)
                req_data[j][e] = 8'(16 * (j + 1) + e);

        req_count = '1;
        #3;
        check("reset.ack",   64'(req_ack),       64'd0);
        check("reset.valid", 64'(fifo_valid_in), 64'd0);
        check("reset.data",  64'(fifo_data_in),  64'd0);
        check("reset.gid",   64'(grant_id),      64'd0);
        check("reset.lock",  64'(starve_lock),   64'd0);

        for (int i = 0; i < 8; i++) begin
            reset_dut();
            fill = vt[i].fill;
            req_count = vt[i].cnt;
            @(negedge clk);
            check($sformatf("vec%0d.ack", i), 64'(req_ack), 64'(vt[i].ack));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.valid", i), 64'(fifo_valid_in), 64'(vt[i].valid));
            check($sformatf("vec%0d.gid", i),   64'(grant_id),      64'(vt[i].gid));
            check($sformatf("vec%0d.lock", i),  64'(starve_lock),   64'd0);
            if (vt[i].valid != 0) begin
                for (int e = 0; e < N; e++) exp_d[e] = 8'(16 * (int'(vt[i].gid) + 1) + e);
                check($sformatf("vec%0d.data", i), 64'(fifo_data_in), 64'(exp_d));
            end
        end

        // Round-robin: everyone requests one element continuously.
        reset_dut();
        req_count = {3'd1, 3'd1, 3'd1, 3'd1};
        for (int c = 0; c < 5; c++) begin
            cycle_check("rr");
            check($sformatf("rr.order%0d", c), 64'(last_ack), 64'(4'b0001 << (c % 4)));
        end

        // Fit skipping followed by the starvation lock.
        reset_dut();
        fill = 5'd14;
        req_count = {3'd0, 3'd0, 3'd2, 3'd3};
        cycle_check("skip1");
        check("skip1.grant", 64'(last_ack), 64'(4'b0010));
        req_count[1] = 3'd1;
        cycle_check("skip2");
        check("skip2.grant", 64'(last_ack), 64'd0);
        check("skip2.lock",  64'(starve_lock), 64'd1);
        cycle_check("lock_hold");
        check("lock_hold.grant", 64'(last_ack), 64'd0);
        fill = 5'd13;
        cycle_check("lock_release");
        check("lock_release.grant", 64'(last_ack), 64'(4'b0001));
        check("lock_release.lock",  64'(starve_lock), 64'd0);
        fill = 5'd0;
        req_count = {3'd0, 3'd1, 3'd1, 3'd0};
        cycle_check("after_lock");
        check("after_lock.grant", 64'(last_ack), 64'(4'b0010));

        // In-flight elements count against free space until fill_level catches up.
        reset_dut();
        fill = 5'd12;
        req_count = {3'd0, 3'd0, 3'd0, 3'd4};
        cycle_check("inflight0");
        check("inflight0.grant", 64'(last_ack), 64'(4'b0001));
        req_count = {3'd0, 3'd0, 3'd1, 3'd0};
        cycle_check("inflight1");
        check("inflight1.grant", 64'(last_ack), 64'd0);
        fill = 5'd16;
        cycle_check("inflight2");
        check("inflight2.grant", 64'(last_ack), 64'd0);

        // Asynchronous reset in the middle of a presented burst.
        reset_dut();
        req_count = {3'd0, 3'd3, 3'd0, 3'd0};
        cycle_check("rst_pre");
        check("rst_pre.valid", 64'(fifo_valid_in), 64'd3);
        req_count = {3'd1, 3'd1, 3'd1, 3'd1};
        #1;
        rstn = 1'b0;
        #1;
        check("rst_async.valid", 64'(fifo_valid_in), 64'd0);
        check("rst_async.lock",  64'(starve_lock),   64'd0);
        check("rst_async.ack",   64'(req_ack),       64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_post.ack", 64'(req_ack), 64'(4'b0001));
        @(posedge clk);
        #1;
        check("rst_post.gid",   64'(grant_id),      64'd0);
        check("rst_post.valid", 64'(fifo_valid_in), 64'd1);

        // Randomized traffic with a modelled FIFO draining slowly.
        reset_dut();
        fill_i = 0;
        for (int j = 0; j < R; j++) req_count[j] = IB'($urandom_range(0, N));
        for (int c = 0; c < 800; c++) begin
            cycle_check("rnd");
            deq = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, (fill_i < 3) ? fill_i : 3);
            fill_i = fill_i + prev_valid - deq;
            fill = CB'(fill_i);
            for (int j = 0; j < R; j++) begin
                if (prev_g == j || (req_count[j] == '0 && $urandom_range(0, 2) == 0)) begin
                    req_count[j] = ($urandom_range(0, 3) == 0) ? '0 : IB'($urandom_range(1, N));
                    for (int e = 0; e < N; e++) req_data[j][e] = 8'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
